spi_master: RTL

Parametrised SPI master with byte-wide register interface, TX/RX FIFOs, programmable SCK divider, all four SPI modes, MSB/LSB-first ordering and up to 8 slave-select lines. Sits on the 8-bit CPU peripheral bus like the other bus slaves. Queued bytes are transferred back-to-back without CPU intervention. A level interrupt is raised when received data or an overflow needs service.

---
 rtl/spi_master.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI master: byte-wide register interface, TX/RX FIFOs, programmable SCK divider,
// all four SPI modes, MSB/LSB-first ordering and software-driven slave selects.

module spi_master_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the same cycle pops an entry.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// state | meaning
// IDLE  | no byte in flight, SCK parked at CPOL, MOSI low
// LOAD  | pop TX head into shifter, latch mode bits and divider
// SHIFT | 16 SCK half-periods, RX byte pushed after the last edge
module spi_master #(
  parameter int NSS        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [1:0]     i_addr,
  input  logic           i_cs,
  input  logic           i_we,
  input  logic [7:0]     i_dat,
  output logic [7:0]     o_dat,
  input  logic           i_miso,
  output logic           o_mosi,
  output logic           o_sck,
  output logic [NSS-1:0] o_ss_n,
  output logic           o_irq
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t         state_q, state_d;
  logic [3:0]     ctrl_q;
  logic [7:0]     div_q;
  logic [NSS-1:0] ss_q;
  logic           ovf_q;

  logic           reg_wr, reg_rd;
  logic           tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0]     tx_dout;
  logic           rx_push, rx_pop, rx_empty, rx_full, rx_ovf;
  logic [7:0]     rx_dout, rx_din;

  logic [7:0]     sh_q, rx_q, rx_nxt, div_cnt_q, div_l;
  logic [3:0]     edge_cnt_q;
  logic           mosi_q, sck_tog_q, cpol_l, cpha_l, lsb_l;
  logic           sck_edge, edge_lead, edge_last, do_sample, do_shift;
  logic           cur_bit, nxt_bit, busy;
  logic [7:0]     ss_rd;

  assign reg_wr  = i_cs && i_we;
  assign reg_rd  = i_cs && !i_we;
  assign tx_push = reg_wr && (i_addr == 2'd1) && !tx_full;
  assign rx_pop  = reg_rd && (i_addr == 2'd1);
  assign rx_ovf  = rx_push && rx_full && !rx_pop;

  spi_master_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (i_clk),
    .reset (i_reset),
    .push  (tx_push),
    .din   (i_dat),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .empty (tx_empty),
    .full  (tx_full)
  );

  spi_master_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (i_clk),
    .reset (i_reset),
    .push  (rx_push),
    .din   (rx_din),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .empty (rx_empty),
    .full  (rx_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctrl_q <= '0;
      div_q  <= '0;
      ss_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (reg_wr) begin
        case (i_addr)
          2'd0:    ctrl_q <= i_dat[3:0];
          2'd2:    div_q  <= i_dat;
          2'd3:    ss_q   <= i_dat[NSS-1:0];
          default: ;
        endcase
      end
      // A fresh overflow wins over a clear written in the same cycle.
      if (rx_ovf)
        ovf_q <= 1'b1;
      else if (reg_wr && (i_addr == 2'd0) && i_dat[4])
        ovf_q <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE) || !tx_empty;

  always_comb begin
    ss_rd          = '0;
    ss_rd[NSS-1:0] = ss_q;
    case (i_addr)
      2'd0:    o_dat = {busy, tx_full, !rx_empty, ovf_q, ctrl_q};
      2'd1:    o_dat = rx_empty ? 8'h00 : rx_dout;
      2'd2:    o_dat = div_q;
      default: o_dat = ss_rd;
    endcase
  end

  assign sck_edge  = (state_q == SHIFT) && (div_cnt_q == 8'd0);
  assign edge_lead = sck_edge && !edge_cnt_q[0];
  assign edge_last = sck_edge && (edge_cnt_q == 4'd15);
  assign do_sample = cpha_l ? (sck_edge && !edge_lead) : edge_lead;
  assign do_shift  = cpha_l ? edge_lead : (sck_edge && !edge_lead && !edge_last);
  assign cur_bit   = lsb_l ? sh_q[0] : sh_q[7];
  assign nxt_bit   = lsb_l ? sh_q[1] : sh_q[6];
  assign rx_nxt    = lsb_l ? {i_miso, rx_q[7:1]} : {rx_q[6:0], i_miso};
  assign rx_din    = do_sample ? rx_nxt : rx_q;

  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    case (state_q)
      IDLE: if (!tx_empty || tx_push) state_d = LOAD;
      LOAD: begin
        tx_pop  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (edge_last) begin
        rx_push = 1'b1;
        state_d = tx_empty ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sh_q       <= '0;
      rx_q       <= '0;
      mosi_q     <= 1'b0;
      sck_tog_q  <= 1'b0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      div_l      <= '0;
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      lsb_l      <= 1'b0;
    end else if (state_q == LOAD) begin
      sh_q       <= tx_dout;
      rx_q       <= '0;
      sck_tog_q  <= 1'b0;
      div_cnt_q  <= div_q;
      edge_cnt_q <= '0;
      div_l      <= div_q;
      cpha_l     <= ctrl_q[0];
      cpol_l     <= ctrl_q[1];
      lsb_l      <= ctrl_q[2];
      // CPHA=0 presents the first bit before the first edge.
      mosi_q     <= ctrl_q[0] ? 1'b0 : (ctrl_q[2] ? tx_dout[0] : tx_dout[7]);
    end else if (state_q == SHIFT) begin
      if (sck_edge) begin
        div_cnt_q  <= div_l;
        edge_cnt_q <= edge_cnt_q + 4'd1;
        sck_tog_q  <= ~sck_tog_q;
      end else begin
        div_cnt_q  <= div_cnt_q - 8'd1;
      end
      if (do_sample) rx_q <= rx_nxt;
      if (do_shift) begin
        sh_q   <= lsb_l ? {1'b0, sh_q[7:1]} : {sh_q[6:0], 1'b0};
        mosi_q <= cpha_l ? cur_bit : nxt_bit;
      end
    end
  end

  assign o_sck  = (state_q == SHIFT) ? (cpol_l ^ sck_tog_q) : ctrl_q[1];
  assign o_mosi = (state_q == IDLE) ? 1'b0 : mosi_q;
  assign o_ss_n = ~ss_q;
  assign o_irq  = ctrl_q[3] && (!rx_empty || ovf_q);
endmodule
